uart_irq_regf: RTL and testbench



---
 rtl/uart_irq_regf.sv | 174 +++++++++++++++++
 tb/tb_uart_irq_regf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_irq_regf.sv
// Multi-channel UART control/status/interrupt register file.
// Optional per-channel event counters: define UART_IRQ_REGF_EVCNT_EN.
module uart_irq_regf #(
  parameter int CH_NUM = 4,
  parameter int MODE_W = 2,
  parameter int EV_W   = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                     main_clk_i,
  input  logic                     main_rst_an_i,
  input  logic                     mem_ena_i,
  input  logic [ADDR_W-1:0]        mem_addr_i,
  input  logic                     mem_wena_i,
  input  logic [DATA_W-1:0]        mem_wdata_i,
  output logic [DATA_W-1:0]        mem_rdata_o,
  output logic                     mem_err_o,
  output logic [CH_NUM-1:0]        regf_ena_o,
  output logic [CH_NUM*MODE_W-1:0] regf_mode_o,
  input  logic [CH_NUM-1:0]        regf_busy_i,
  input  logic [CH_NUM*EV_W-1:0]   regf_ev_i,
  output logic                     irq_o
);

  if (DATA_W != 32) begin : g_dw_chk
    $error("uart_irq_regf: DATA_W must be 32");
  end

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [ADDR_W-1:0] SUM_A = ADDR_W'(4 * CH_NUM);

  logic [CH_NUM-1:0]             ena_q;
  logic [CH_NUM-1:0][MODE_W-1:0] mode_q;
  logic [CH_NUM-1:0][EV_W-1:0]   stat_q;
  logic [CH_NUM-1:0][EV_W-1:0]   mask_q;
  logic [CH_NUM-1:0][EV_W-1:0]   ev;
  logic [CH_NUM-1:0]             pend;
`ifdef UART_IRQ_REGF_EVCNT_EN
  logic [CH_NUM-1:0][7:0]        cnt_q;
`endif

  logic [CH_W-1:0]   ch;
  logic [1:0]        slot;
  logic              in_ch;
  logic              is_sum;
  logic              acc_err;
  logic              wr_go;
  logic [DATA_W-1:0] rd_word;
  logic [CH_NUM-1:0] ctrl_we;
  logic [CH_NUM-1:0] irq_we;
  logic [CH_NUM-1:0] cnt_we;
  logic              unused_wdata;

  assign ev           = regf_ev_i;
  assign ch           = mem_addr_i[2 +: CH_W];
  assign slot         = mem_addr_i[1:0];
  assign in_ch        = mem_addr_i < SUM_A;
  assign is_sum       = mem_addr_i == SUM_A;
  assign regf_ena_o   = ena_q;
  assign regf_mode_o  = mode_q;
  assign unused_wdata = ^mem_wdata_i;

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      pend[c] = |(stat_q[c] & mask_q[c]);
    end
  end

  always_comb begin
    rd_word = '0;
    acc_err = 1'b0;
    unique case (1'b1)
      in_ch: begin
        case (slot)
          2'd0: rd_word[MODE_W:0] = {mode_q[ch], ena_q[ch]};
          2'd1: begin
            rd_word[0] = regf_busy_i[ch];
            acc_err    = mem_wena_i;
          end
          2'd2: begin
            rd_word[EV_W-1:0]   = stat_q[ch];
            rd_word[16 +: EV_W] = mask_q[ch];
          end
          default: begin
`ifdef UART_IRQ_REGF_EVCNT_EN
            rd_word[7:0] = cnt_q[ch];
`else
            acc_err = 1'b1;
`endif
          end
        endcase
      end
      is_sum: begin
        rd_word[CH_NUM-1:0] = pend;
        acc_err             = mem_wena_i;
      end
      default: acc_err = 1'b1;
    endcase
  end

  assign wr_go = mem_ena_i & mem_wena_i & in_ch & ~acc_err;

  always_comb begin
    ctrl_we = '0;
    irq_we  = '0;
    cnt_we  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_go && ch == CH_W'(c)) begin
        ctrl_we[c] = slot == 2'd0;
        irq_we[c]  = slot == 2'd2;
        cnt_we[c]  = slot == 2'd3;
      end
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      ena_q  <= '0;
      mode_q <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      irq_o <= |pend;
      for (int c = 0; c < CH_NUM; c++) begin
        if (ctrl_we[c]) begin
          ena_q[c]  <= mem_wdata_i[0];
          mode_q[c] <= mem_wdata_i[MODE_W:1];
        end
        if (irq_we[c]) begin
          mask_q[c] <= mem_wdata_i[16 +: EV_W];
        end
        // events win over a same-cycle clear
        stat_q[c] <= (stat_q[c]
                      & ~(irq_we[c] ? mem_wdata_i[EV_W-1:0] : '0))
                     | ev[c];
      end
    end
  end

`ifdef UART_IRQ_REGF_EVCNT_EN
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (cnt_we[c]) begin
          cnt_q[c] <= {7'd0, |ev[c]};
        end else if (|ev[c] && cnt_q[c] != 8'hFF) begin
          cnt_q[c] <= cnt_q[c] + 8'd1;
        end
      end
    end
  end
`else
  logic unused_cnt_we;
  assign unused_cnt_we = ^cnt_we;
`endif

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
    end else if (mem_ena_i) begin
      mem_err_o <= acc_err;
      if (!mem_wena_i) begin
        mem_rdata_o <= acc_err ? '0 : rd_word;
      end
    end else begin
      mem_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_irq_regf.sv
// Directed bench for uart_irq_regf with a per-cycle reference model.
module tb_uart_irq_regf;

  localparam int CH = 4;
`ifdef UART_IRQ_REGF_EVCNT_EN
  localparam bit EVC = 1'b1;
`else
  localparam bit EVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ena = 1'b0;
  logic [12:0] mem_addr = '0;
  logic        mem_wena = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [3:0]  regf_ena;
  logic [7:0]  regf_mode;
  logic [3:0]  regf_busy = '0;
  logic [15:0] regf_ev = '0;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  uart_irq_regf dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .mem_ena_i     (mem_ena),
    .mem_addr_i    (mem_addr),
    .mem_wena_i    (mem_wena),
    .mem_wdata_i   (mem_wdata),
    .mem_rdata_o   (mem_rdata),
    .mem_err_o     (mem_err),
    .regf_ena_o    (regf_ena),
    .regf_mode_o   (regf_mode),
    .regf_busy_i   (regf_busy),
    .regf_ev_i     (regf_ev),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  logic        m_ena [CH];
  logic [1:0]  m_mode[CH];
  logic [3:0]  m_stat[CH];
  logic [3:0]  m_mask[CH];
  int          m_cnt [CH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_irq;

  function automatic logic [3:0] evc(int c);
    logic [15:0] e;
    e = regf_ev;
    return e[c*4 +: 4];
  endfunction

  function automatic logic [3:0] pend_vec();
    logic [3:0] p;
    for (int c = 0; c < CH; c++) p[c] = (m_stat[c] & m_mask[c]) != 0;
    return p;
  endfunction

  function automatic bit ok(int a, logic w);
    if (a > 4*CH) return 1'b0;
    if (a == 4*CH) return !w;
    if (a % 4 == 1) return !w;
    if (a % 4 == 3) return EVC;
    return 1'b1;
  endfunction

  function automatic logic [31:0] rd_val(int a);
    int c;
    c = a / 4;
    if (a == 4*CH) return {28'd0, pend_vec()};
    case (a % 4)
      0: return {29'd0, m_mode[c], m_ena[c]};
      1: return {31'd0, regf_busy[c]};
      2: return {12'd0, m_mask[c], 12'd0, m_stat[c]};
      default: return 32'(m_cnt[c]);
    endcase
  endfunction

  function automatic bit hit(int c, int s);
    return mem_ena && mem_wena && int'(mem_addr) == 4*c + s
           && ok(int'(mem_addr), 1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_ena[c]  <= 1'b0;
        m_mode[c] <= '0;
        m_stat[c] <= '0;
        m_mask[c] <= '0;
        m_cnt[c]  <= 0;
      end
      m_rdata <= '0;
      m_err   <= 1'b0;
      m_irq   <= 1'b0;
    end else begin
      m_irq <= pend_vec() != 0;
      m_err <= mem_ena && !ok(int'(mem_addr), mem_wena);
      if (mem_ena && !mem_wena)
        m_rdata <= ok(int'(mem_addr), 1'b0) ? rd_val(int'(mem_addr)) : '0;
      for (int c = 0; c < CH; c++) begin
        m_stat[c] <= (m_stat[c] & ~(hit(c, 2) ? mem_wdata[3:0] : 4'h0))
                     | evc(c);
        if (hit(c, 0)) begin
          m_ena[c]  <= mem_wdata[0];
          m_mode[c] <= mem_wdata[2:1];
        end
        if (hit(c, 2)) m_mask[c] <= mem_wdata[19:16];
        if (hit(c, 3)) m_cnt[c] <= (evc(c) != 0) ? 1 : 0;
        else if (evc(c) != 0 && m_cnt[c] < 255) m_cnt[c] <= m_cnt[c] + 1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] e_ena();
    logic [3:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_ena[c];
    return r;
  endfunction

  function automatic logic [7:0] e_mode();
    logic [7:0] r;
    for (int c = 0; c < CH; c++) r[c*2 +: 2] = m_mode[c];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rdata", mem_rdata, m_rdata);
      chk("m_err", 32'(mem_err), 32'(m_err));
      chk("m_irq", 32'(irq), 32'(m_irq));
      chk("m_ena", 32'(regf_ena), 32'(e_ena()));
      chk("m_mode", 32'(regf_mode), 32'(e_mode()));
    end
  end

  task automatic bus(logic w, int a, logic [31:0] d);
    @(negedge clk);
    mem_ena   = 1'b1;
    mem_wena  = w;
    mem_addr  = 13'(a);
    mem_wdata = d;
    regf_ev   = '0;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_ena  = 1'b0;
    mem_wena = 1'b0;
    regf_ev  = '0;
  endtask

  task automatic rd(string name, int a, logic [31:0] exp);
    bus(1'b0, a, '0);
    idle();
    chk(name, mem_rdata, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ena", 32'(regf_ena), 32'h0);
    rst_n = 1'b1;

    for (int a = 0; a <= 16; a++) begin
      rd("rd_rst", a, 32'h0);
      chk("rd_rst_err", 32'(mem_err), (!EVC && a % 4 == 3) ? 1 : 0);
    end
    rd("rd_17", 17, 32'h0);
    chk("err_17", 32'(mem_err), 32'h1);
    idle();
    chk("err_17_one", 32'(mem_err), 32'h0);

    bus(1'b1, 4, 32'h5);
    idle();
    chk("ena_ch1", 32'(regf_ena), 32'h2);
    chk("mode_ch1", 32'(regf_mode[3:2]), 32'h2);
    rd("rd_ctrl1", 4, 32'h5);

    regf_busy = 4'b1000;
    rd("rd_busy3", 13, 32'h1);
    bus(1'b1, 13, 32'hFFFF_FFFF);
    idle();
    chk("err_ro", 32'(mem_err), 32'h1);
    rd("rd_busy3_b", 13, 32'h1);

    bus(1'b1, 10, 32'h000F_0000);
    idle();
    @(negedge clk);
    regf_ev = 16'h0400;
    idle();
    chk("irq_n1", 32'(irq), 32'h0);
    idle();
    chk("irq_n2", 32'(irq), 32'h1);
    rd("rd_irq2", 10, 32'h000F_0004);
    rd("rd_sum", 16, 32'h4);

    bus(1'b1, 10, 32'h000F_0004);
    regf_ev = 16'h0400;
    idle();
    idle();
    chk("irq_setwin", 32'(irq), 32'h1);
    rd("rd_setwin", 10, 32'h000F_0004);
    bus(1'b1, 10, 32'h000F_0004);
    idle();
    chk("irq_clr_1", 32'(irq), 32'h1);
    idle();
    chk("irq_clr_2", 32'(irq), 32'h0);
    rd("rd_clr", 10, 32'h000F_0000);

    @(negedge clk);
    regf_ev = 16'h0001;
    idle();
    idle();
    chk("irq_masked", 32'(irq), 32'h0);
    bus(1'b1, 2, 32'h0001_0000);
    idle();
    chk("irq_mask_1", 32'(irq), 32'h0);
    idle();
    chk("irq_mask_2", 32'(irq), 32'h1);
    rd("rd_sum2", 16, 32'h1);

    bus(1'b1, 16, 32'h0);
    bus(1'b0, 6, 32'h0);
    bus(1'b1, 8, 32'h3);
    bus(1'b0, 8, 32'h0);
    idle();
    chk("b2b_rd", mem_rdata, 32'h3);

    bus(1'b0, 4, 32'h0);
    #2;
    rst_n   = 1'b0;
    mem_ena = 1'b0;
    @(negedge clk);
    chk("midrst_rdata", mem_rdata, 32'h0);
    chk("midrst_err", 32'(mem_err), 32'h0);
    chk("midrst_ena", 32'(regf_ena), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    rd("rd_after_rst", 10, 32'h0);

    if (EVC) begin
      @(negedge clk);
      regf_ev = 16'h0001;
      repeat (300) @(negedge clk);
      idle();
      rd("cnt_sat", 3, 32'hFF);
      bus(1'b1, 3, 32'h0);
      idle();
      chk("cnt_wr_err", 32'(mem_err), 32'h0);
      rd("cnt_clr", 3, 32'h0);
      bus(1'b1, 3, 32'h0);
      regf_ev = 16'h0001;
      idle();
      rd("cnt_wr_ev", 3, 32'h1);
    end else begin
      rd("rd_slot3", 3, 32'h0);
      chk("err_slot3", 32'(mem_err), 32'h1);
    end

    repeat (3) idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
